// File: rtl/lr35902_dma_pkg.sv
// Shared constants and state encoding for the LR35902 OAM DMA controller.
// Source-page helpers live here so the controller and any future users agree on the mapping.
package lr35902_dma_pkg;

  localparam logic [7:0] DMA_REG_ADR  = 8'h46;
  localparam int         NBYTES       = 160;
  localparam int         CYC_PER_BYTE = 4;
  localparam int         START_CYC    = 4;

  localparam logic [7:0] VRAM_PAGE_LO = 8'h80;
  localparam logic [7:0] VRAM_PAGE_HI = 8'h9F;

  localparam logic [1:0] LAST_PHASE   = 2'(CYC_PER_BYTE - 1);
  localparam logic [1:0] LATCH_PHASE  = 2'(CYC_PER_BYTE - 2);
  localparam logic [1:0] START_LAST   = 2'(START_CYC - 1);
  localparam logic [7:0] LAST_IDX     = 8'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER
  } dma_state_e;

  // Pages E0-FF are the echo of work RAM at C0-DF.
  function automatic logic [7:0] effPage(input logic [7:0] src);
    return (src >= 8'hE0) ? (src & 8'hDF) : src;
  endfunction

  function automatic logic isVramPage(input logic [7:0] page);
    return (page >= VRAM_PAGE_LO) && (page <= VRAM_PAGE_HI);
  endfunction

endpackage

// File: rtl/lr35902_oam_dma.sv
// OAM DMA controller: owns FF46 and copies 160 bytes from a source page into OAM,
// one byte per M-cycle, after a one M-cycle start delay.
module lr35902_oam_dma
  import lr35902_dma_pkg::*;
(
  input  logic        clk,
  input  logic        n_reset,
  input  logic [7:0]  adr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        read,
  input  logic        write,
  output logic [15:0] adr_dma_rd,
  output logic        rd_dma,
  input  logic [7:0]  data_dma_in,
  output logic [7:0]  adr_dma_wr,
  output logic [7:0]  data_dma_out,
  output logic        wr_dma,
  output logic        dma_active,
  output logic        dma_drvext
);

  dma_state_e state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] data_q, data_d;
  logic       regWrPrev_q;

  logic       regWr;
  logic       startEvt;
  logic [7:0] page;

  // The write strobe is a level, so only its rising edge on FF46 starts a transfer.
  assign regWr    = write && (adr == DMA_REG_ADR);
  assign startEvt = regWr && !regWrPrev_q;
  assign page     = effPage(src_q);

  assign dout = (read && (adr == DMA_REG_ADR)) ? src_q : 8'hFF;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      src_q       <= 8'h00;
      idx_q       <= 8'h00;
      phase_q     <= 2'd0;
      data_q      <= 8'h00;
      regWrPrev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      data_q      <= data_d;
      regWrPrev_q <= regWr;
    end
  end

  // A start event always wins, so a restart abandons the byte in flight before its write phase.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    data_d  = data_q;
    if (startEvt) begin
      state_d = START;
      src_d   = din;
      idx_d   = 8'h00;
      phase_d = 2'd0;
    end else begin
      case (state_q)
        START: begin
          if (phase_q == START_LAST) begin
            state_d = XFER;
            phase_d = 2'd0;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
        XFER: begin
          phase_d = phase_q + 2'd1;
          if (phase_q == LATCH_PHASE) begin
            data_d = data_dma_in;
          end
          if (phase_q == LAST_PHASE) begin
            idx_d = idx_q + 8'd1;
            if (idx_q == LAST_IDX) begin
              state_d = IDLE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    adr_dma_rd   = 16'h0000;
    rd_dma       = 1'b0;
    wr_dma       = 1'b0;
    dma_drvext   = 1'b0;
    adr_dma_wr   = idx_q;
    data_dma_out = data_q;
    dma_active   = (state_q != IDLE);
    if (state_q == XFER) begin
      adr_dma_rd = {page, idx_q};
      rd_dma     = (phase_q != LAST_PHASE);
      wr_dma     = (phase_q == LAST_PHASE);
      dma_drvext = !isVramPage(page);
    end
  end

endmodule

// File: tb/tb_lr35902_oam_dma.sv
// Self-checking bench for lr35902_oam_dma: random transfers compared cycle by cycle
// against a timeline model derived from the start edge and the source register.
module tb_lr35902_oam_dma;

  logic        clk = 1'b0;
  logic        n_reset = 1'b1;
  logic [7:0]  adr = 8'h00;
  logic [7:0]  din = 8'h00;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  dout;
  logic [15:0] adr_dma_rd;
  logic        rd_dma;
  logic [7:0]  data_dma_in;
  logic [7:0]  adr_dma_wr;
  logic [7:0]  data_dma_out;
  logic        wr_dma;
  logic        dma_active;
  logic        dma_drvext;

  int checks = 0;
  int errors = 0;

  int         edgeCnt = 0;
  int         startEdge = -100000;
  bit         modelBusy = 1'b0;
  bit         modelPrev = 1'b0;
  logic [7:0] modelSrc = 8'h00;
  bit         checkEn = 1'b0;
  int         wrCount = 0;
  int         activeCnt = 0;
  logic [7:0] oam [0:255];

  int          sk, sj;
  logic [7:0]  sPage;
  logic [15:0] eAdrRd;
  logic        eRd, eWr, eDrv, eAct;
  logic [7:0]  eDout;

  lr35902_oam_dma dut (
    .clk(clk),
    .n_reset(n_reset),
    .adr(adr),
    .din(din),
    .dout(dout),
    .read(read),
    .write(write),
    .adr_dma_rd(adr_dma_rd),
    .rd_dma(rd_dma),
    .data_dma_in(data_dma_in),
    .adr_dma_wr(adr_dma_wr),
    .data_dma_out(data_dma_out),
    .wr_dma(wr_dma),
    .dma_active(dma_active),
    .dma_drvext(dma_drvext)
  );

  always #5 clk = ~clk;

  // Source memory content depends on both address bytes so wrong pages show up as wrong data.
  function automatic logic [7:0] srcByte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  assign data_dma_in = srcByte(adr_dma_rd);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Model of the register: a rising qualified write on FF46 records the source and the start edge.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      modelBusy = 1'b0;
      modelPrev = 1'b0;
      modelSrc  = 8'h00;
    end else begin
      edgeCnt++;
      if (write && adr == 8'h46 && !modelPrev) begin
        modelBusy = 1'b1;
        startEdge = edgeCnt;
        modelSrc  = din;
      end
      modelPrev = write && (adr == 8'h46);
    end
  end

  // Cycle k after the start edge: 1..4 idle M-cycle, then 4 cycles per byte, 644 in all.
  always @(negedge clk) begin
    if (checkEn) begin
      sk = edgeCnt - startEdge + 1;
      if (modelBusy && sk > 644) modelBusy = 1'b0;
      eAct   = modelBusy;
      eRd    = 1'b0;
      eWr    = 1'b0;
      eDrv   = 1'b0;
      eAdrRd = 16'h0000;
      if (modelBusy && sk >= 5) begin
        sj     = sk - 5;
        sPage  = (modelSrc >= 8'hE0) ? modelSrc - 8'h20 : modelSrc;
        eAdrRd = {sPage, 8'(sj / 4)};
        eRd    = (sj % 4) < 3;
        eWr    = (sj % 4) == 3;
        eDrv   = !(sPage >= 8'h80 && sPage <= 8'h9F);
      end
      eDout = (read && adr == 8'h46) ? modelSrc : 8'hFF;
      checkOutput("dma_active", dma_active, eAct);
      checkOutput("rd_dma", rd_dma, eRd);
      checkOutput("wr_dma", wr_dma, eWr);
      checkOutput("dma_drvext", dma_drvext, eDrv);
      checkOutput("adr_dma_rd", adr_dma_rd, eAdrRd);
      checkOutput("dout", dout, eDout);
      if (eWr) begin
        checkOutput("adr_dma_wr", adr_dma_wr, 32'(sj / 4));
        checkOutput("data_dma_out", data_dma_out, srcByte(eAdrRd));
      end
      if (wr_dma) begin
        oam[adr_dma_wr] = data_dma_out;
        wrCount++;
      end
      if (dma_active) activeCnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input int holdCyc);
    tick();
    adr   = a;
    din   = d;
    write = 1'b1;
    repeat (holdCyc) tick();
    write = 1'b0;
    adr   = 8'h00;
  endtask

  // Runs until the transfer ends, sprinkling random reads and writes to other registers.
  task automatic waitIdle(input int budget);
    int n = 0;
    while (dma_active && n < budget) begin
      adr = 8'($urandom_range(0, 255));
      read = ($urandom_range(0, 3) == 0);
      write = ($urandom_range(0, 7) == 0);
      if (write && adr == 8'h46) adr = 8'h47;
      if (!write && $urandom_range(0, 1) == 1) adr = 8'h46;
      din = 8'($urandom);
      tick();
      n++;
    end
    read = 1'b0;
    write = 1'b0;
    adr = 8'h00;
    tick();
    checkOutput("idleTimeout", dma_active, 0);
  endtask

  task automatic fullTransfer(input logic [7:0] src);
    for (int i = 0; i < 256; i++) oam[i] = 8'h00;
    wrCount = 0;
    activeCnt = 0;
    applyStimulus(8'h46, src, 1);
    waitIdle(800);
    checkOutput("wrCount", wrCount, 160);
    checkOutput("activeCnt", activeCnt, 644);
  endtask

  task automatic restartAt(input logic [7:0] src1, input logic [7:0] src2, input int rk);
    int n = 0;
    wrCount = 0;
    activeCnt = 0;
    applyStimulus(8'h46, src1, 1);
    while ((edgeCnt - startEdge + 1) != rk && n < 800) begin
      tick();
      n++;
    end
    checkOutput("restartReach", n < 800, 1);
    adr = 8'h46;
    din = src2;
    write = 1'b1;
    tick();
    write = 1'b0;
    adr = 8'h00;
    waitIdle(800);
    checkOutput("restartWrCount", wrCount, (rk - 4) / 4 + 160);
    checkOutput("restartActiveCnt", activeCnt, rk + 644);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] pg;
    #1 n_reset = 1'b0;
    #2;
    checkOutput("rstActive", dma_active, 0);
    checkOutput("rstWr", wr_dma, 0);
    checkOutput("rstRd", rd_dma, 0);
    checkOutput("rstAdrRd", adr_dma_rd, 0);
    checkOutput("rstAdrWr", adr_dma_wr, 0);
    checkOutput("rstData", data_dma_out, 0);
    checkEn = 1'b1;
    tick();
    n_reset = 1'b1;
    repeat (3) tick();

    fullTransfer(8'hC1);
    for (int i = 0; i < 160; i++) begin
      checkOutput("oam", oam[i], srcByte({8'hC1, 8'(i)}));
    end

    fullTransfer(8'h80);
    fullTransfer(8'h7F);
    fullTransfer(8'hE3);
    tick();
    adr = 8'h46;
    read = 1'b1;
    #1 checkOutput("echoReadback", dout, 8'hE3);
    tick();
    read = 1'b0;

    for (int r = 0; r < 4; r++) begin
      pg = 8'($urandom);
      fullTransfer(pg);
    end

    restartAt(8'hC0, 8'hD0, 206);
    restartAt(8'($urandom), 8'($urandom), $urandom_range(5, 640));

    activeCnt = 0;
    applyStimulus(8'h47, 8'h12, 1);
    repeat (4) tick();
    checkOutput("isoNoStart", activeCnt, 0);
    adr = 8'h46;
    read = 1'b1;
    #1 checkOutput("isoDout", dout, modelSrc);
    tick();
    read = 1'b0;

    wrCount = 0;
    activeCnt = 0;
    applyStimulus(8'h46, 8'h55, 3);
    waitIdle(800);
    checkOutput("holdWrCount", wrCount, 160);
    checkOutput("holdActiveCnt", activeCnt, 644);

    applyStimulus(8'h46, 8'hC1, 1);
    repeat (100) tick();
    #2 n_reset = 1'b0;
    #1;
    checkOutput("midRstActive", dma_active, 0);
    checkOutput("midRstRd", rd_dma, 0);
    checkOutput("midRstWr", wr_dma, 0);
    checkOutput("midRstDrv", dma_drvext, 0);
    checkOutput("midRstAdrRd", adr_dma_rd, 0);
    checkOutput("midRstAdrWr", adr_dma_wr, 0);
    tick();
    n_reset = 1'b1;
    tick();
    adr = 8'h46;
    read = 1'b1;
    #1 checkOutput("doutAfterReset", dout, 8'h00);
    tick();
    read = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
